// File: rtl/golden_nonce_queue.sv
// Multi-core golden-nonce collector: per-core capture registers, a round-robin
// arbiter and a show-ahead FIFO with core tagging and a saturating overflow count.
module golden_nonce_queue #(
    parameter int LOCAL_MINERS  = 2,
    parameter int NONCE_WIDTH   = 32,
    parameter int DEPTH         = 4,
    parameter int CORE_ID_WIDTH = 4,
    parameter int OVF_WIDTH     = 16
) (
    input  logic                                hash_clk,
    input  logic                                reset,
    input  logic [LOCAL_MINERS*NONCE_WIDTH-1:0] golden_nonce_i,
    input  logic [LOCAL_MINERS-1:0]             golden_nonce_match,
    output logic [NONCE_WIDTH-1:0]              out_nonce,
    output logic [CORE_ID_WIDTH-1:0]            out_core,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LOCAL_MINERS-1:0]             pending,
    output logic [$clog2(DEPTH):0]              fifo_level,
    output logic [OVF_WIDTH-1:0]                overflow_count
);

    localparam int RRW    = (LOCAL_MINERS > 1) ? $clog2(LOCAL_MINERS) : 1;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVLW   = ADDR_W + 1;
    localparam int SUMW   = OVF_WIDTH + 5;

    logic [NONCE_WIDTH-1:0]   cap [LOCAL_MINERS];
    logic [RRW-1:0]           rr;
    logic [RRW-1:0]           grant_idx;
    logic                     grant_found;
    logic                     grant_en;
    logic                     pop;
    logic [LOCAL_MINERS-1:0]  ovf_hit;
    logic [SUMW-1:0]          ovf_sum;

    logic [NONCE_WIDTH-1:0]   mem_nonce [DEPTH];
    logic [CORE_ID_WIDTH-1:0] mem_core  [DEPTH];
    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        rd_ptr;

    // First pending core scanning cyclically upward from the round-robin pointer.
    always_comb begin
        logic [RRW:0] cand;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < LOCAL_MINERS; k++) begin
            cand = {1'b0, rr} + (RRW+1)'(k);
            if (cand >= (RRW+1)'(LOCAL_MINERS))
                cand = cand - (RRW+1)'(LOCAL_MINERS);
            if (!grant_found && pending[cand[RRW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[RRW-1:0];
            end
        end
    end

    assign grant_en  = grant_found && (fifo_level < LVLW'(DEPTH));
    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;
    assign out_nonce = out_valid ? mem_nonce[rd_ptr] : '0;
    assign out_core  = out_valid ? mem_core[rd_ptr]  : '0;

    // A re-match only counts as an overwrite if the old capture is not leaving this cycle.
    always_comb begin
        ovf_hit = '0;
        for (int i = 0; i < LOCAL_MINERS; i++)
            ovf_hit[i] = golden_nonce_match[i] && pending[i] &&
                         !(grant_en && grant_idx == RRW'(i));
        ovf_sum = SUMW'(overflow_count) + SUMW'($countones(ovf_hit));
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            pending        <= '0;
            rr             <= '0;
            overflow_count <= '0;
            for (int i = 0; i < LOCAL_MINERS; i++)
                cap[i] <= '0;
        end else begin
            for (int i = 0; i < LOCAL_MINERS; i++) begin
                if (golden_nonce_match[i]) begin
                    cap[i]     <= golden_nonce_i[i*NONCE_WIDTH +: NONCE_WIDTH];
                    pending[i] <= 1'b1;
                end else if (grant_en && grant_idx == RRW'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
            if (grant_en) begin
                if (int'(grant_idx) == LOCAL_MINERS - 1)
                    rr <= '0;
                else
                    rr <= grant_idx + 1'b1;
            end
            if (ovf_sum > SUMW'({OVF_WIDTH{1'b1}}))
                overflow_count <= '1;
            else
                overflow_count <= ovf_sum[OVF_WIDTH-1:0];
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (grant_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (grant_en && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (!grant_en && pop)
                fifo_level <= fifo_level - 1'b1;
        end
    end

    // Storage needs no reset: out_valid gates the head onto the outputs.
    always_ff @(posedge hash_clk) begin
        if (grant_en) begin
            mem_nonce[wr_ptr] <= cap[grant_idx];
            mem_core[wr_ptr]  <= CORE_ID_WIDTH'(grant_idx);
        end
    end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Directed bench for golden_nonce_queue with eight cores and a four-entry FIFO.
module tb_golden_nonce_queue;

    localparam int LM  = 8;
    localparam int NW  = 32;
    localparam int DP  = 4;
    localparam int CIW = 4;
    localparam int OW  = 16;

    logic              hash_clk = 1'b0;
    logic              reset;
    logic [LM*NW-1:0]  golden_nonce_i;
    logic [LM-1:0]     golden_nonce_match;
    logic [NW-1:0]     out_nonce;
    logic [CIW-1:0]    out_core;
    logic              out_valid;
    logic              out_ready;
    logic [LM-1:0]     pending;
    logic [2:0]        fifo_level;
    logic [OW-1:0]     overflow_count;

    int errors = 0;
    int checks = 0;

    golden_nonce_queue #(
        .LOCAL_MINERS(LM), .NONCE_WIDTH(NW), .DEPTH(DP),
        .CORE_ID_WIDTH(CIW), .OVF_WIDTH(OW)
    ) dut (
        .hash_clk(hash_clk), .reset(reset),
        .golden_nonce_i(golden_nonce_i), .golden_nonce_match(golden_nonce_match),
        .out_nonce(out_nonce), .out_core(out_core), .out_valid(out_valid),
        .out_ready(out_ready), .pending(pending), .fifo_level(fifo_level),
        .overflow_count(overflow_count)
    );

    always #5 hash_clk = ~hash_clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic set_match(input int core, input logic [NW-1:0] val);
        golden_nonce_i[core*NW +: NW] = val;
        golden_nonce_match[core]      = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; golden_nonce_i = '0; golden_nonce_match = '0; out_ready = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL reset_pending got %h want 00", pending); end
        checks++; if (overflow_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_ovf got %0d want 0", overflow_count); end
        checks++; if (out_nonce !== 32'd0 || out_core !== 4'd0) begin errors++; $display("[TB] FAIL reset_head got %h/%0d want 0/0", out_nonce, out_core); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single(input int core, input logic [NW-1:0] val);
        out_ready = 1'b1;
        set_match(core, val);
        tick();
        golden_nonce_match = '0;
        checks++; if (pending !== 8'(1 << core)) begin errors++; $display("[TB] FAIL single_pending got %h want %h", pending, 8'(1 << core)); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid got %0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_nonce !== val) begin errors++; $display("[TB] FAIL single_nonce got %h want %h", out_nonce, val); end
        checks++; if (out_core !== 4'(core)) begin errors++; $display("[TB] FAIL single_core got %0d want %0d", out_core, core); end
        checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL single_pending_clr got %h want 00", pending); end
        tick();
        checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL single_drained got valid=%0b level=%0d want 0/0", out_valid, fifo_level); end
    endtask

    // All four low cores match at once; exp packs the expected delivery order, first in the top nibble.
    task automatic test_round_robin(input logic [15:0] exp);
        logic [3:0] c;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_match(i, 32'h10 + i);
        tick();
        golden_nonce_match = '0;
        checks++; if (pending !== 8'h0F) begin errors++; $display("[TB] FAIL rr_pending got %h want 0f", pending); end
        tick();
        for (int k = 0; k < 4; k++) begin
            c = exp[15 - 4*k -: 4];
            checks++; if (out_valid !== 1'b1 || out_core !== c || out_nonce !== 32'h10 + 32'(c))
                begin errors++; $display("[TB] FAIL rr_order[%0d] got v=%0b core=%0d nonce=%h want core=%0d nonce=%h", k, out_valid, out_core, out_nonce, c, 32'h10 + 32'(c)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) set_match(i, 32'h20 + i);
        tick();
        golden_nonce_match = '0;
        repeat (5) tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL bp_level got %0d want 4", fifo_level); end
        checks++; if (pending !== 8'h30) begin errors++; $display("[TB] FAIL bp_pending got %h want 30", pending); end
        checks++; if (overflow_count !== 16'd0) begin errors++; $display("[TB] FAIL bp_ovf got %0d want 0", overflow_count); end
        checks++; if (out_core !== 4'd0 || out_nonce !== 32'h20) begin errors++; $display("[TB] FAIL bp_hold got %0d/%h want 0/00000020", out_core, out_nonce); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (out_valid !== 1'b1 || out_core !== 4'(k) || out_nonce !== 32'h20 + 32'(k))
                begin errors++; $display("[TB] FAIL bp_drain[%0d] got v=%0b core=%0d nonce=%h want core=%0d", k, out_valid, out_core, out_nonce, k); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL bp_empty got v=%0b pend=%h want 0/00", out_valid, pending); end
    endtask

    // FIFO is filled by cores 4..7 (rr=6 beforehand) so core 0's two captures collide.
    task automatic test_overflow();
        logic [3:0] cores [5];
        logic [NW-1:0] vals [5];
        cores = '{4'd6, 4'd7, 4'd4, 4'd5, 4'd0};
        vals  = '{32'h46, 32'h47, 32'h44, 32'h45, 32'h22};
        out_ready = 1'b0;
        for (int i = 4; i < 8; i++) set_match(i, 32'h40 + i);
        tick();
        golden_nonce_match = '0;
        repeat (4) tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_full got %0d want 4", fifo_level); end
        set_match(0, 32'h11);
        tick();
        golden_nonce_match = '0;
        tick();
        set_match(0, 32'h22);
        tick();
        golden_nonce_match = '0;
        checks++; if (overflow_count !== 16'd1) begin errors++; $display("[TB] FAIL ovf_count got %0d want 1", overflow_count); end
        checks++; if (pending !== 8'h01) begin errors++; $display("[TB] FAIL ovf_pending got %h want 01", pending); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out_core !== cores[k] || out_nonce !== vals[k])
                begin errors++; $display("[TB] FAIL ovf_drain[%0d] got v=%0b core=%0d nonce=%h want core=%0d nonce=%h", k, out_valid, out_core, out_nonce, cores[k], vals[k]); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_grant_rematch();
        out_ready = 1'b1;
        set_match(0, 32'h44);
        tick();
        set_match(0, 32'h55);
        tick();
        golden_nonce_match = '0;
        checks++; if (out_valid !== 1'b1 || out_nonce !== 32'h44) begin errors++; $display("[TB] FAIL remat_first got v=%0b nonce=%h want 1/00000044", out_valid, out_nonce); end
        checks++; if (pending !== 8'h01) begin errors++; $display("[TB] FAIL remat_pending got %h want 01", pending); end
        checks++; if (overflow_count !== 16'd1) begin errors++; $display("[TB] FAIL remat_ovf got %0d want 1", overflow_count); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_nonce !== 32'h55 || out_core !== 4'd0) begin errors++; $display("[TB] FAIL remat_second got v=%0b nonce=%h core=%0d want 1/00000055/0", out_valid, out_nonce, out_core); end
        tick();
        checks++; if (out_valid !== 1'b0 || pending !== 8'h00) begin errors++; $display("[TB] FAIL remat_empty got v=%0b pend=%h want 0/00", out_valid, pending); end
    endtask

    task automatic test_midstream_reset();
        out_ready = 1'b0;
        for (int i = 1; i < 4; i++) set_match(i, 32'h60 + i);
        tick();
        golden_nonce_match = '0;
        repeat (3) tick();
        checks++; if (fifo_level !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre got level=%0d v=%0b want 3/1", fifo_level, out_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL mid_async got v=%0b level=%0d want 0/0", out_valid, fifo_level); end
        checks++; if (pending !== 8'h00 || overflow_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_async_state got pend=%h ovf=%0d want 00/0", pending, overflow_count); end
        tick();
        reset = 1'b0;
        tick();
        test_single(1, 32'h000000AB);
    endtask

    initial begin
        test_reset();
        test_single(1, 32'h000000AB);
        test_round_robin(16'h2301);
        test_single(7, 32'h77);
        test_round_robin(16'h0123);
        test_single(7, 32'h77);
        test_backpressure();
        test_overflow();
        test_grant_rematch();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/golden_nonce_queue.md
Name: golden_nonce_queue

Overview:
- Parametrised multi-core golden-nonce collector for the miner top level.
- Captures single-cycle match pulses from LOCAL_MINERS hashcores and arbitrates them round-robin into a DEPTH-entry FIFO.
- Presents nonces on a valid/ready output tagged with the originating core ID.
- Adds what the flag-and-mux collector lacks: output buffering, backpressure, a core tag, and an overflow count.

Parameters:
- LOCAL_MINERS, 2, number of hashcores (1..16).
- NONCE_WIDTH, 32, width of each nonce.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CORE_ID_WIDTH, 4, width of the core tag; must satisfy 2^CORE_ID_WIDTH ≥ LOCAL_MINERS.
- OVF_WIDTH, 16, width of the overflow counter.

Ports:
- hash_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- golden_nonce_i  in  LOCAL_MINERS*NONCE_WIDTH  core i nonce at bits [(i+1)*NONCE_WIDTH-1 : i*NONCE_WIDTH].
- golden_nonce_match  in  LOCAL_MINERS  per-core one-cycle match pulse; nonce valid in the same cycle.
- out_nonce  out  NONCE_WIDTH  FIFO head nonce.
- out_core  out  CORE_ID_WIDTH  FIFO head core index.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- pending  out  LOCAL_MINERS  per-core captured-not-yet-queued flags.
- fifo_level  out  clog2(DEPTH)+1  entries held, 0..DEPTH.
- overflow_count  out  OVF_WIDTH  saturating count of overwritten captures.

Behaviour:
- Reset (async assert, sync release):
  - pending, capture registers, FIFO pointers, fifo_level, round-robin pointer rr and overflow_count go to 0.
  - out_valid=0, out_nonce=0, out_core=0.
  - Effect is immediate, including mid-operation; queued nonces are discarded.
- Capture, per core i, each edge:
  - match[i] loads cap[i] with the nonce and sets pending[i].
  - match[i] while pending[i]=1 and core i not granted this cycle: newest nonce overwrites cap[i]; overflow_count increments, saturating at all-ones.
  - match[i] in the same cycle core i is granted: granted (old) value goes to the FIFO; cap[i] loads the new nonce; pending[i] stays 1; no overflow.
  - Several cores matching in the same cycle are all captured independently.
- Arbitration (combinational grant, registered effects):
  - grant_en = (fifo_level < DEPTH) and any pending bit set.
  - Grant the first pending index scanning cyclically from rr: rr, rr+1, …, LOCAL_MINERS-1, 0, …
  - On grant g: write {g, cap[g]} to FIFO, clear pending[g] (unless re-matched per above), rr <= (g+1) mod LOCAL_MINERS.
  - At most one grant per cycle. No grant when fifo_level==DEPTH, even if a pop occurs in the same cycle.
  - rr unchanged when there is no grant.
- FIFO:
  - Show-ahead: out_nonce/out_core reflect the head entry whenever out_valid=1 and are held stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves fifo_level unchanged. Pointers wrap mod DEPTH.
  - out_valid = (fifo_level != 0), driven from registered state.
  - out_ready while empty has no effect.
- Latency:
  - Match sampled at edge E0 -> pending visible after E0.
  - With the FIFO not full and no competing core, grant at E1 -> out_valid high after E1, i.e. 2 cycles from the match pulse.
  - Each competing pending core ahead in round-robin order adds 1 cycle.
- Widths: core tag is the grant index zero-extended to CORE_ID_WIDTH; fifo_level is unsigned.

Test Plan:
- LOCAL_MINERS=2, core 1 pulses match with nonce 0x000000AB, out_ready=1 -> out_valid rises 2 cycles later with out_nonce=0x000000AB, out_core=1 for one cycle; then fifo_level=0, pending=0.
- LOCAL_MINERS=4, rr=0, all four match simultaneously with 0x10..0x13, out_ready=1 -> outputs appear in order core 0,1,2,3 on consecutive cycles. Repeat with rr=2 -> order 2,3,0,1.
- LOCAL_MINERS=8, DEPTH=4, out_ready=0, cores 0..5 match once -> fifo_level=4, pending=0x30, overflow_count=0; then out_ready=1 -> all six nonces emerge in round-robin order, none lost.
- out_ready=0 with FIFO full; core 0 matches 0x11, then 0x22 two cycles later -> overflow_count=1; after draining, core 0 delivers 0x22 only.
- Core 0 is granted in the same cycle it re-matches with 0x55 (old 0x44) -> 0x44 is queued, pending[0] stays 1, 0x55 follows, overflow_count unchanged.
- fifo_level=3, out_valid=1; assert reset for 1 cycle mid-stream -> out_valid, fifo_level, pending and overflow_count go to 0 without waiting for a clock edge; the first match after release behaves as in the first scenario.
